// File: rtl/shared_fir_scheduler.sv
// shared_fir_scheduler: one MAC time-shared across NUM_CH FIR channels with a
// common coefficient set. Each tick_i computes all channel outputs, one tap
// per cycle, and publishes them together with a single tick_o.
// Optional build macro: SHARED_FIR_SAT_EN (saturating output scaling instead of wrap).
module shared_fir_scheduler #(
    parameter int NUM_CH       = 2,
    parameter int COEFF_LENGTH = 41,
    parameter int BITWIDTH     = 24
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic                             tick_i,
    input  logic [NUM_CH*BITWIDTH-1:0]       data_i,
    input  logic [COEFF_LENGTH*BITWIDTH-1:0] coeff_i,
    output logic [NUM_CH*BITWIDTH-1:0]       data_o,
    output logic                             tick_o,
    output logic                             busy_o,
    output logic                             overrun_o
);
    localparam int AW = 2*BITWIDTH + $clog2(COEFF_LENGTH);
    localparam int KW = $clog2(COEFF_LENGTH);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(COEFF_LENGTH-1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_CH-1);

    typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_e;

    state_e                                      state_q, state_d;
    logic [CW-1:0]                               ch_q, ch_d;
    logic [KW-1:0]                               k_q, k_d;
    logic [NUM_CH-1:0][BITWIDTH-1:0]             din_w;
    logic [COEFF_LENGTH-1:0][BITWIDTH-1:0]       coeff_w;
    logic [NUM_CH-1:0][COEFF_LENGTH-1:0][BITWIDTH-1:0] hist_q;
    logic [NUM_CH-1:0][BITWIDTH-1:0]             stage_q, out_q;
    logic signed [BITWIDTH-1:0]                  samp_s, tap_s;
    logic signed [AW-1:0]                        acc_q, samp_w, tap_w, prod_w, shifted_w;
    logic [BITWIDTH-1:0]                         scaled_w;
    logic                                        tick_q, busy_q, ovr_q;

    assign din_w   = data_i;
    assign coeff_w = coeff_i;

    // Operands are sign-extended to accumulator width so the product is exact.
    assign samp_s    = hist_q[ch_q][k_q];
    assign tap_s     = coeff_w[k_q];
    assign samp_w    = {{(AW-BITWIDTH){samp_s[BITWIDTH-1]}}, samp_s};
    assign tap_w     = {{(AW-BITWIDTH){tap_s[BITWIDTH-1]}}, tap_s};
    assign prod_w    = samp_w * tap_w;
    assign shifted_w = acc_q >>> (BITWIDTH-1);

`ifdef SHARED_FIR_SAT_EN
    // In range when every bit from the output sign bit upward agrees.
    logic fits_w;
    assign fits_w   = (&shifted_w[AW-1:BITWIDTH-1]) | ~(|shifted_w[AW-1:BITWIDTH-1]);
    assign scaled_w = fits_w ? shifted_w[BITWIDTH-1:0] :
                      (shifted_w[AW-1] ? {1'b1, {(BITWIDTH-1){1'b0}}}
                                       : {1'b0, {(BITWIDTH-1){1'b1}}});
`else
    // Two's-complement wrap: the high bits are simply dropped.
    logic unused_hi;
    assign unused_hi = ^shifted_w[AW-1:BITWIDTH];
    assign scaled_w  = shifted_w[BITWIDTH-1:0];
`endif

    // Sequencer state, channel and tap counters.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ch_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            k_q     <= k_d;
        end
    end

    // Next state: walk every tap of a channel, store, then the next channel.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        k_d     = k_q;
        case (state_q)
            IDLE: if (tick_i) begin
                state_d = MAC;
                ch_d    = '0;
                k_d     = '0;
            end
            MAC: begin
                if (k_q == K_LAST) state_d = STORE;
                else               k_d     = k_q + 1'b1;
            end
            STORE: begin
                k_d = '0;
                if (ch_q == C_LAST) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = MAC;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: delay lines, accumulator, staging and published outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hist_q  <= '0;
            acc_q   <= '0;
            stage_q <= '0;
            out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (tick_i) begin
                    for (int c = 0; c < NUM_CH; c++)
                        hist_q[c] <= {hist_q[c][COEFF_LENGTH-2:0], din_w[c]};
                    acc_q <= '0;
                end
                MAC:   acc_q <= acc_q + prod_w;
                STORE: begin
                    stage_q[ch_q] <= scaled_w;
                    acc_q         <= '0;
                end
                DONE:  out_q <= stage_q;
                default: ;
            endcase
        end
    end

    // Status flags; a tick outside IDLE is dropped and latched as overrun.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tick_q <= 1'b0;
            busy_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            tick_q <= (state_q == DONE);
            busy_q <= (state_d != IDLE);
            if (tick_i && state_q != IDLE) ovr_q <= 1'b1;
        end
    end

    assign data_o    = out_q;
    assign tick_o    = tick_q;
    assign busy_o    = busy_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_shared_fir_scheduler.sv
// Randomized self-checking bench for shared_fir_scheduler against a
// convolution model kept as plain arrays of sample history and taps.
module tb_shared_fir_scheduler;
    localparam int NC = 2;
    localparam int L  = 41;
    localparam int BW = 24;
    localparam int LAT = NC*(L+1) + 1;
    localparam longint CMAX = 8388607;

    logic              clk;
    logic              reset_ni;
    logic              tick_i;
    logic [NC*BW-1:0]  data_i;
    logic [L*BW-1:0]   coeff_i;
    logic [NC*BW-1:0]  data_o;
    logic              tick_o, busy_o, overrun_o;

    longint hist_m [NC][L];
    longint c_m    [L];
    bit     exp_ovr;
    int     n_chk, n_pass;

    shared_fir_scheduler #(.NUM_CH(NC), .COEFF_LENGTH(L), .BITWIDTH(BW)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .tick_i(tick_i), .data_i(data_i),
        .coeff_i(coeff_i), .data_o(data_o), .tick_o(tick_o), .busy_o(busy_o),
        .overrun_o(overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic longint rnd24();
        logic signed [BW-1:0] v;
        v = BW'($urandom);
        return longint'(v);
    endfunction

    function automatic longint sdo(input int ch);
        logic signed [BW-1:0] v;
        v = data_o[ch*BW +: BW];
        return longint'(v);
    endfunction

    // FIR output from the model history: full sum, floor-shift, then wrap or clamp.
    function automatic longint model_out(input int ch);
        longint s, q;
        s = 0;
        for (int k = 0; k < L; k++) s += hist_m[ch][k] * c_m[k];
        q = s >>> (BW-1);
`ifdef SHARED_FIR_SAT_EN
        if (q > CMAX)       q = CMAX;
        if (q < -CMAX - 1)  q = -CMAX - 1;
`else
        q = q & ((longint'(1) << BW) - 1);
        if (q > CMAX) q -= (longint'(1) << BW);
`endif
        return q;
    endfunction

    task automatic drive_coeff();
        for (int k = 0; k < L; k++) coeff_i[k*BW +: BW] = c_m[k][BW-1:0];
    endtask

    task automatic set_data(input longint d0, input longint d1);
        data_i[0 +: BW]  = d0[BW-1:0];
        data_i[BW +: BW] = d1[BW-1:0];
    endtask

    task automatic set_tap_only(input int tap, input longint val);
        for (int k = 0; k < L; k++) c_m[k] = 0;
        c_m[tap] = val;
        drive_coeff();
    endtask

    // One accepted tick; optionally a second tick_i at inj_at cycles after it.
    task automatic run_tick(input longint d0, input longint d1, input int inj_at, input string tag);
        int n;
        bit seen;
        set_data(d0, d1);
        tick_i = 1'b1;
        @(posedge clk); #1;
        tick_i = 1'b0;
        for (int ch = 0; ch < NC; ch++)
            for (int k = L-1; k > 0; k--) hist_m[ch][k] = hist_m[ch][k-1];
        hist_m[0][0] = d0;
        hist_m[1][0] = d1;
        chk({tag, ".busy_start"}, longint'(busy_o), 1);
        chk({tag, ".tick_low"}, longint'(tick_o), 0);
        n = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            if (n == inj_at) begin
                tick_i = 1'b1;
                set_data(123, -321);
                exp_ovr = 1'b1;
            end
            @(posedge clk); #1;
            tick_i = 1'b0;
            n++;
            if (n == 40) chk({tag, ".busy_mid"}, longint'(busy_o), 1);
            seen = tick_o;
        end
        chk({tag, ".latency"}, n, LAT);
        chk({tag, ".busy_end"}, longint'(busy_o), 0);
        chk({tag, ".ch0"}, sdo(0), model_out(0));
        chk({tag, ".ch1"}, sdo(1), model_out(1));
        chk({tag, ".overrun"}, longint'(overrun_o), longint'(exp_ovr));
    endtask

    // Start a computation, then pull reset low 40 cycles in.
    task automatic reset_mid_op();
        int cnt;
        set_data(rnd24(), rnd24());
        tick_i = 1'b1;
        @(posedge clk); #1;
        tick_i = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        reset_ni = 1'b0;
        #1;
        chk("rst.data", longint'(data_o), 0);
        chk("rst.busy", longint'(busy_o), 0);
        chk("rst.overrun", longint'(overrun_o), 0);
        chk("rst.tick", longint'(tick_o), 0);
        for (int ch = 0; ch < NC; ch++)
            for (int k = 0; k < L; k++) hist_m[ch][k] = 0;
        exp_ovr = 1'b0;
        @(posedge clk); #1;
        reset_ni = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (tick_o) cnt++;
        end
        chk("rst.no_tick", cnt, 0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        exp_ovr = 1'b0;
        tick_i = 1'b0;
        data_i = '0;
        coeff_i = '0;
        for (int ch = 0; ch < NC; ch++)
            for (int k = 0; k < L; k++) hist_m[ch][k] = 0;
        for (int k = 0; k < L; k++) c_m[k] = 0;
        reset_ni = 1'b1;
        #2 reset_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.data", longint'(data_o), 0);
        chk("reset.tick", longint'(tick_o), 0);
        chk("reset.busy", longint'(busy_o), 0);
        chk("reset.overrun", longint'(overrun_o), 0);
        reset_ni = 1'b1;
        @(posedge clk); #1;

        // Impulse response at tap 0.
        set_tap_only(0, CMAX);
        run_tick(1000, -2000, -1, "delta");
        chk("delta.lit0", sdo(0), 999);
        chk("delta.lit1", sdo(1), -2000);

        // Tap-1 delay; second tick injected mid-computation must be dropped.
        set_tap_only(1, CMAX);
        run_tick(5, 5, 10, "ovr_a");
        chk("ovr_a.lit0", sdo(0), 999);
        run_tick(7, 7, -1, "ovr_b");
        chk("ovr_b.lit0", sdo(0), 4);
        chk("ovr_b.sticky", longint'(overrun_o), 1);

        reset_mid_op();

        // Zeroed history after reset, back-to-back ticks.
        set_tap_only(1, CMAX);
        run_tick(1000, -2000, -1, "zero");
        chk("zero.lit0", sdo(0), 0);
        chk("zero.lit1", sdo(1), 0);
        run_tick(5, 5, -1, "dly");
        chk("dly.lit0", sdo(0), 999);
        chk("dly.lit1", sdo(1), -2000);

        // Output range limit with two full-scale taps.
        for (int k = 0; k < L; k++) c_m[k] = 0;
        c_m[0] = CMAX;
        c_m[1] = CMAX;
        drive_coeff();
        run_tick(8000000, 0, -1, "sat_a");
        run_tick(8000000, 0, -1, "sat_b");
`ifdef SHARED_FIR_SAT_EN
        chk("sat.lit", sdo(0), 8388607);
`else
        chk("sat.lit", sdo(0), -777218);
`endif

        // Random coefficients and samples.
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < L; k++) c_m[k] = rnd24();
            drive_coeff();
            run_tick(rnd24(), rnd24(), -1, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
